comparator_bist: RTL



---
 rtl/comp_pkg.sv | 34 +++
 rtl/comparator_bist.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/comp_pkg.sv
// Shared types and the expected-result function for the comparator self-test.
package comp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int CMP_EQ = 0;
   localparam int CMP_GT = 1;
   localparam int CMP_LT = 2;

   localparam int unsigned VEC_W    = 2;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned SETTLE_W = 8;
   localparam int unsigned PASS_W   = 4;
   localparam int unsigned LOG_W    = 4;

   localparam logic [CNT_W-1:0] FAIL_CNT_MAX = CNT_W'(15);

   // Golden 1-bit compare result for the selected function.
   function automatic logic cmp_expected(logic a, logic b, int func);
      logic r;
      case (func)
         CMP_GT:  r = a & ~b;
         CMP_LT:  r = ~a & b;
         default: r = ~(a ^ b);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/comparator_bist.sv
// Self-test driver/checker for a 1-bit comparator: sweeps all four (a,b) vectors,
// samples res after a settle window and reports mismatch statistics.
module comparator_bist
   import comp_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned N_PASSES      = 1,
   parameter int          CMP_FUNC      = CMP_EQ
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   output logic             a_o,
   output logic             b_o,
   input  logic             res_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic [VEC_W-1:0] fail_vec_o,
   output logic [LOG_W-1:0] res_log_o
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("comparator_bist: SETTLE_CYCLES must be 1..255");
   end
   if (N_PASSES < 1 || N_PASSES > 15) begin : g_bad_passes
      $error("comparator_bist: N_PASSES must be 1..15");
   end
   if (CMP_FUNC != CMP_EQ && CMP_FUNC != CMP_GT && CMP_FUNC != CMP_LT) begin : g_bad_func
      $error("comparator_bist: CMP_FUNC must be 0, 1 or 2");
   end

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [PASS_W-1:0]   PASS_LAST   = PASS_W'(N_PASSES - 1);
   localparam logic [VEC_W-1:0]    VEC_LAST    = VEC_W'(3);

   state_t              state_q, state_d;
   logic [VEC_W-1:0]    vec_q, vec_d;
   logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;

   logic                a_d, b_d, busy_d, done_d, pass_d;
   logic [CNT_W-1:0]    fail_cnt_d;
   logic [VEC_W-1:0]    fail_vec_d;
   logic [LOG_W-1:0]    res_log_d;
   logic                exp_res;

   // State, counters and all outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         pass_idx_q <= '0;
         settle_q   <= '0;
         a_o        <= 1'b0;
         b_o        <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         fail_cnt_o <= '0;
         fail_vec_o <= '0;
         res_log_o  <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         pass_idx_q <= pass_idx_d;
         settle_q   <= settle_d;
         a_o        <= a_d;
         b_o        <= b_d;
         busy_o     <= busy_d;
         done_o     <= done_d;
         pass_o     <= pass_d;
         fail_cnt_o <= fail_cnt_d;
         fail_vec_o <= fail_vec_d;
         res_log_o  <= res_log_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      pass_idx_d = pass_idx_q;
      settle_d   = settle_q;
      a_d        = a_o;
      b_d        = b_o;
      busy_d     = busy_o;
      done_d     = 1'b0;
      pass_d     = pass_o;
      fail_cnt_d = fail_cnt_o;
      fail_vec_d = fail_vec_o;
      res_log_d  = res_log_o;
      exp_res    = cmp_expected(vec_q[1], vec_q[0], CMP_FUNC);

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = SETTLE;
               vec_d      = '0;
               pass_idx_d = '0;
               settle_d   = '0;
               a_d        = 1'b0;
               b_d        = 1'b0;
               busy_d     = 1'b1;
               pass_d     = 1'b0;
               fail_cnt_d = '0;
               fail_vec_d = '0;
               res_log_d  = '0;
            end
         end

         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = SAMPLE;
            end else begin
               settle_d = settle_q + SETTLE_W'(1);
            end
         end

         SAMPLE: begin
            res_log_d[vec_q] = res_i;
            if (res_i != exp_res) begin
               if (fail_cnt_o != FAIL_CNT_MAX) fail_cnt_d = fail_cnt_o + CNT_W'(1);
               if (fail_cnt_o == '0)           fail_vec_d = vec_q;
            end
            vec_d = vec_q + VEC_W'(1);
            if (vec_q == VEC_LAST && pass_idx_q == PASS_LAST) begin
               // Pass verdict must include the mismatch recorded on this final sample.
               state_d    = DONE;
               vec_d      = '0;
               pass_idx_d = '0;
               a_d        = 1'b0;
               b_d        = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               pass_d     = (fail_cnt_d == '0);
            end else begin
               if (vec_q == VEC_LAST) pass_idx_d = pass_idx_q + PASS_W'(1);
               state_d = SETTLE;
               a_d     = vec_d[1];
               b_d     = vec_d[0];
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
